// File: rtl/rect_plotter_if.sv
// Request/pixel bundle between a rectangle client and rect_plotter.
// The slave side is the plotter; the master side is whoever issues draws.
interface rect_plotter_if #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [1:0]          mode;
  logic [X_W-1:0]      originX;
  logic [Y_W-1:0]      originY;
  logic [X_W-1:0]      rectW;
  logic [Y_W-1:0]      rectH;
  logic [COLOUR_W-1:0] colour;
  logic [COLOUR_W-1:0] bgColour;
  logic                hold;
  logic [X_W-1:0]      vgaX;
  logic [Y_W-1:0]      vgaY;
  logic [COLOUR_W-1:0] vgaColour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output start, mode, originX, originY, rectW, rectH, colour, bgColour, hold,
    input  vgaX, vgaY, vgaColour, plot, busy, done
  );

  modport slave (
    input  start, mode, originX, originY, rectW, rectH, colour, bgColour, hold,
    output vgaX, vgaY, vgaColour, plot, busy, done
  );
endinterface

// File: rtl/rect_plotter.sv
// Rectangle draw engine: walks a latched rectangle in raster order, one cell
// per non-held clock, emitting registered pixel coordinates, colour and plot.
module rect_plotter #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input logic         clock,
  input logic         reset,
  rect_plotter_if.slave rp
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [X_W:0]   SW    = SCREEN_W[X_W:0];
  localparam logic [Y_W:0]   SH    = SCREEN_H[Y_W:0];
  localparam logic [X_W-1:0] X_ONE = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [X_W-1:0]      col_q, col_d, org_x_q, org_x_d, w_q, w_d;
  logic [Y_W-1:0]      row_q, row_d, org_y_q, org_y_d, h_q, h_d;
  logic [1:0]          mode_q, mode_d;
  logic [COLOUR_W-1:0] fg_q, fg_d, bg_q, bg_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_c_q, vga_c_d;
  logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  logic         last_col, last_row, in_bounds, selected, is_clear;

  // Sums are one bit wider so off-screen cells past the field range still clip.
  assign sum_x     = {1'b0, org_x_q} + {1'b0, col_q};
  assign sum_y     = {1'b0, org_y_q} + {1'b0, row_q};
  assign in_bounds = (sum_x < SW) && (sum_y < SH);
  assign last_col  = (col_q == w_q - X_ONE);
  assign last_row  = (row_q == h_q - Y_ONE);
  assign is_clear  = (mode_q == 2'b10);
  assign selected  = (mode_q != 2'b01) || (col_q == '0) || last_col ||
                     (row_q == '0) || last_row;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    w_d     = w_q;
    h_d     = h_q;
    mode_d  = mode_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    vga_x_d = vga_x_q;
    vga_y_d = vga_y_q;
    vga_c_d = vga_c_q;
    plot_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rp.start) begin
          org_x_d = rp.originX;
          org_y_d = rp.originY;
          w_d     = rp.rectW;
          h_d     = rp.rectH;
          mode_d  = rp.mode;
          fg_d    = rp.colour;
          bg_d    = rp.bgColour;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = (rp.rectW == '0 || rp.rectH == '0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        // Clipped and outline-interior cells still take their cycle, plot=0.
        if (!rp.hold) begin
          vga_x_d = sum_x[X_W-1:0];
          vga_y_d = sum_y[Y_W-1:0];
          vga_c_d = is_clear ? bg_q : fg_q;
          plot_d  = in_bounds && selected;
          if (last_col) begin
            col_d = '0;
            row_d = row_q + Y_ONE;
            if (last_row) state_d = DONE;
          end else begin
            col_d = col_q + X_ONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      org_x_q <= '0;
      org_y_q <= '0;
      w_q     <= '0;
      h_q     <= '0;
      mode_q  <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      vga_c_q <= vga_c_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rp.vgaX      = vga_x_q;
  assign rp.vgaY      = vga_y_q;
  assign rp.vgaColour = vga_c_q;
  assign rp.plot      = plot_q;
  assign rp.busy      = busy_q;
  assign rp.done      = done_q;
endmodule

// File: tb/tb_rect_plotter.sv
// Scoreboard bench for rect_plotter: directed draws push hand-listed pixels,
// a negedge monitor pops and compares every plotted pixel.
module tb_rect_plotter;
  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  pix_t expq[$];

  rect_plotter_if #(.X_W(9), .Y_W(8), .COLOUR_W(3)) rp ();

  rect_plotter #(
    .X_W(9), .Y_W(8), .COLOUR_W(3), .SCREEN_W(320), .SCREEN_H(240)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rp   (rp.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int c);
    pix_t p;
    p.x = x; p.y = y; p.c = c;
    expq.push_back(p);
  endtask

  // Monitor: every plot strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (rp.done) done_cnt++;
    if (rp.plot) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got (%0d,%0d,%0d) expected none",
                 rp.vgaX, rp.vgaY, rp.vgaColour);
      end else begin
        pix_t e;
        e = expq.pop_front();
        if (int'(rp.vgaX) != e.x || int'(rp.vgaY) != e.y || int'(rp.vgaColour) != e.c) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   rp.vgaX, rp.vgaY, rp.vgaColour, e.x, e.y, e.c);
        end
      end
    end
  end

  // Issue one draw; hold covers edges hs..hs+hl-1, inj pulses a stray start.
  task automatic run(input string name, input logic [1:0] m, input int ox, input int oy,
                     input int w, input int h, input int col, input int bg,
                     input int exp_done, input int hs, input int hl, input int inj);
    int k;
    bit got;
    rp.mode = m; rp.originX = 9'(ox); rp.originY = 8'(oy);
    rp.rectW = 9'(w); rp.rectH = 8'(h);
    rp.colour = 3'(col); rp.bgColour = 3'(bg);
    rp.start = 1'b1;
    @(posedge clock); #1;
    rp.start = 1'b0;
    rp.mode = 2'b10; rp.originX = '0; rp.originY = '0;
    rp.rectW = 9'd1; rp.rectH = 8'd1; rp.colour = ~3'(col); rp.bgColour = ~3'(bg);
    chk({name, "_busy_start"}, int'(rp.busy), 1);
    k = 0; got = 0;
    while (!got && k < 300) begin
      rp.hold  = (k + 1 >= hs) && (k + 1 < hs + hl);
      rp.start = (k + 1 == inj);
      @(posedge clock); #1;
      k++;
      if (k >= hs && k < hs + hl) chk({name, "_held_plot"}, int'(rp.plot), 0);
      if (rp.done) got = 1;
    end
    rp.hold = 1'b0; rp.start = 1'b0;
    chk({name, "_done_edge"}, k, exp_done);
    chk({name, "_busy_at_done"}, int'(rp.busy), 0);
    chk({name, "_pending_pixels"}, expq.size(), 0);
  endtask

  initial begin
    int dc;
    rp.start = 0; rp.mode = 0; rp.originX = 0; rp.originY = 0; rp.rectW = 0;
    rp.rectH = 0; rp.colour = 0; rp.bgColour = 0; rp.hold = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_vgaX", int'(rp.vgaX), 0);
    chk("rst_vgaY", int'(rp.vgaY), 0);
    chk("rst_colour", int'(rp.vgaColour), 0);
    chk("rst_plot", int'(rp.plot), 0);
    chk("rst_busy", int'(rp.busy), 0);
    chk("rst_done", int'(rp.done), 0);
    reset = 1'b0;

    // Fill 4x3 at (10,20)
    for (int y = 20; y <= 22; y++) for (int x = 10; x <= 13; x++) push(x, y, 5);
    run("fill4x3", 2'b00, 10, 20, 4, 3, 5, 2, 13, 0, 0, 0);

    // Outline 4x3 at (10,20): interior (11,21),(12,21) skipped
    push(10,20,3); push(11,20,3); push(12,20,3); push(13,20,3);
    push(10,21,3); push(13,21,3);
    push(10,22,3); push(11,22,3); push(12,22,3); push(13,22,3);
    run("outline", 2'b01, 10, 20, 4, 3, 3, 0, 13, 0, 0, 0);

    // Fill 4x4 at (318,238): clipped to 2x2
    push(318,238,2); push(319,238,2); push(318,239,2); push(319,239,2);
    run("clip", 2'b00, 318, 238, 4, 4, 2, 0, 17, 0, 0, 0);

    // Empty rectangle
    run("empty", 2'b00, 10, 10, 0, 3, 7, 0, 1, 0, 0, 0);

    // Clear 2x2 at (0,0) uses bgColour
    push(0,0,0); push(1,0,0); push(0,1,0); push(1,1,0);
    run("clear", 2'b10, 0, 0, 2, 2, 7, 0, 5, 0, 0, 0);

    // Mode 11 behaves as fill
    push(7,8,4); push(8,8,4);
    run("mode11", 2'b11, 7, 8, 2, 1, 4, 1, 3, 0, 0, 0);

    // Fill 5x1 with hold over edges 3..5
    for (int x = 50; x <= 54; x++) push(x, 60, 6);
    run("hold", 2'b00, 50, 60, 5, 1, 6, 0, 9, 3, 3, 0);

    // Stray start mid-draw is ignored
    for (int y = 100; y <= 101; y++) for (int x = 100; x <= 102; x++) push(x, y, 1);
    run("midstart", 2'b00, 100, 100, 3, 2, 1, 5, 7, 0, 0, 3);

    // Reset mid-draw: three pixels out, then abort
    push(10,20,3); push(11,20,3); push(12,20,3);
    rp.mode = 2'b00; rp.originX = 9'd10; rp.originY = 8'd20;
    rp.rectW = 9'd4; rp.rectH = 8'd3; rp.colour = 3'd3; rp.start = 1'b1;
    @(posedge clock); #1;
    rp.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    dc = done_cnt;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_vgaX", int'(rp.vgaX), 0);
    chk("abort_vgaY", int'(rp.vgaY), 0);
    chk("abort_colour", int'(rp.vgaColour), 0);
    chk("abort_plot", int'(rp.plot), 0);
    chk("abort_busy", int'(rp.busy), 0);
    repeat (20) @(posedge clock);
    #1;
    chk("abort_no_done", done_cnt, dc);
    chk("abort_pending", expq.size(), 0);

    // Fresh draw after abort
    push(5,6,6); push(6,6,6); push(5,7,6); push(6,7,6);
    run("after_abort", 2'b10, 5, 6, 2, 2, 1, 6, 5, 0, 0, 0);

    repeat (4) @(posedge clock);
    #1;
    chk("final_pending", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
